// File: rtl/csv_sfifo_pkg.sv
// csv_sfifo_pkg: shared widths and default thresholds for the csv_sfifo family.
//   ptr_w(depth)   - bits needed to address 0..depth-1 (at least 1)
//   cnt_w(depth)   - bits needed to hold a fill level 0..depth
//   AFULL_OFFSET   - default almost-full threshold sits this far below DEPTH
//   AEMPTY_DEFAULT - default almost-empty threshold
package csv_sfifo_pkg;

    localparam int AFULL_OFFSET   = 4;
    localparam int AEMPTY_DEFAULT = 4;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/csv_sfifo_prog_if.sv
// csv_sfifo_prog_if: producer/consumer handshake and status bundle of csv_sfifo_prog.
//   master modport - the user side (drives requests, write data, error clear)
//   slave modport  - the FIFO side (drives readiness, read data, status, errors)
interface csv_sfifo_prog_if
    import csv_sfifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    logic [WIDTH-1:0]        wdata;
    logic                    i_wreq;
    logic                    o_wready;
    logic                    i_rreq;
    logic                    o_rready;
    logic [WIDTH-1:0]        rdata;
    logic                    o_rvalid;
    logic [cnt_w(DEPTH)-1:0] fifo_count;
    logic                    fifo_isfull;
    logic                    fifo_isempty;
    logic                    fifo_almost_full;
    logic                    fifo_almost_empty;
    logic                    o_overflow;
    logic                    o_underflow;
    logic                    i_clr_err;

    modport master (
        output wdata, i_wreq, i_rreq, i_clr_err,
        input  o_wready, o_rready, rdata, o_rvalid, fifo_count, fifo_isfull,
               fifo_isempty, fifo_almost_full, fifo_almost_empty, o_overflow, o_underflow
    );

    modport slave (
        input  wdata, i_wreq, i_rreq, i_clr_err,
        output o_wready, o_rready, rdata, o_rvalid, fifo_count, fifo_isfull,
               fifo_isempty, fifo_almost_full, fifo_almost_empty, o_overflow, o_underflow
    );
endinterface

// File: rtl/csv_sfifo_dpram.sv
// csv_sfifo_dpram: one-write/one-read synchronous RAM, WIDTH x DEPTH.
//   clk, rst       - clock; rst clears only the read data register, never the array
//   we/waddr/wdata - write port
//   re/raddr/rdata - registered read port, rdata updates on edges with re=1
module csv_sfifo_dpram
    import csv_sfifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/csv_sfifo_prog.sv
// csv_sfifo_prog: single-clock FIFO with arbitrary depth, fill count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//   clk, rst  - clock and synchronous active-high reset
//   fifo_bus  - csv_sfifo_prog_if.slave: write/read handshake, data, status, errors
// Build option CSV_SFIFO_FWFT_EN: first-word-fall-through read mode. The RAM read
// register doubles as the head-word register, so capacity stays DEPTH in total.
module csv_sfifo_prog
    import csv_sfifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int AFULL_TH  = DEPTH - AFULL_OFFSET,
    parameter int AEMPTY_TH = AEMPTY_DEFAULT
) (
    input logic             clk,
    input logic             rst,
    csv_sfifo_prog_if.slave fifo_bus
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_TH    = CW'(AFULL_TH);
    localparam logic [CW-1:0] AE_TH    = CW'(AEMPTY_TH);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          isfull, isempty, afull, aempty, ovf, udf;
    logic          wr_acc, rd_acc, ram_rd, out_valid;

    // Full is judged on the registered count, so a read on the same edge never frees a slot.
    assign wr_acc = fifo_bus.i_wreq && !isfull;

`ifdef CSV_SFIFO_FWFT_EN
    logic [CW-1:0] ram_cnt;

    // Words still in the array, excluding the one parked in the head register.
    assign ram_cnt = cnt - CW'(out_valid);
    assign rd_acc  = fifo_bus.i_rreq && out_valid;
    // Refill whenever the head is empty or being popped; popping and refilling share an edge.
    assign ram_rd  = (ram_cnt != '0) && (!out_valid || rd_acc);

    always_ff @(posedge clk) begin
        if (rst)         out_valid <= 1'b0;
        else if (ram_rd) out_valid <= 1'b1;
        else if (rd_acc) out_valid <= 1'b0;
    end

    assign fifo_bus.o_rready = out_valid;
`else
    assign rd_acc = fifo_bus.i_rreq && !isempty;
    assign ram_rd = rd_acc;

    always_ff @(posedge clk) begin
        if (rst) out_valid <= 1'b0;
        else     out_valid <= rd_acc;
    end

    assign fifo_bus.o_rready = !isempty;
`endif

    always_comb begin
        cnt_nxt = cnt;
        if (wr_acc && !rd_acc)      cnt_nxt = cnt + CW'(1);
        else if (!wr_acc && rd_acc) cnt_nxt = cnt - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            isfull  <= 1'b0;
            isempty <= 1'b1;
            afull   <= 1'b0;
            aempty  <= 1'b1;
            ovf     <= 1'b0;
            udf     <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            if (ram_rd) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            cnt     <= cnt_nxt;
            isfull  <= (cnt_nxt == CNT_FULL);
            isempty <= (cnt_nxt == '0);
            afull   <= (cnt_nxt >= AF_TH);
            aempty  <= (cnt_nxt <= AE_TH);
            // A new error wins over a simultaneous clear.
            ovf     <= (fifo_bus.i_wreq && !wr_acc) || (ovf && !fifo_bus.i_clr_err);
            udf     <= (fifo_bus.i_rreq && !rd_acc) || (udf && !fifo_bus.i_clr_err);
        end
    end

    csv_sfifo_dpram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (fifo_bus.wdata),
        .re    (ram_rd),
        .raddr (rd_ptr),
        .rdata (fifo_bus.rdata)
    );

    assign fifo_bus.o_wready          = !isfull;
    assign fifo_bus.o_rvalid          = out_valid;
    assign fifo_bus.fifo_count        = cnt;
    assign fifo_bus.fifo_isfull       = isfull;
    assign fifo_bus.fifo_isempty      = isempty;
    assign fifo_bus.fifo_almost_full  = afull;
    assign fifo_bus.fifo_almost_empty = aempty;
    assign fifo_bus.o_overflow        = ovf;
    assign fifo_bus.o_underflow       = udf;
endmodule

// File: tb/tb_csv_sfifo_prog.sv
// tb_csv_sfifo_prog: directed self-checking bench for csv_sfifo_prog.
// A DEPTH=32 instance covers the main behaviour; a DEPTH=6 instance covers pointer wrap.
module tb_csv_sfifo_prog;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    csv_sfifo_prog_if #(.WIDTH(8), .DEPTH(32)) b32 ();
    csv_sfifo_prog #(.WIDTH(8), .DEPTH(32)) dut32 (.clk(clk), .rst(rst), .fifo_bus(b32.slave));

    csv_sfifo_prog_if #(.WIDTH(8), .DEPTH(6)) b6 ();
    csv_sfifo_prog #(.WIDTH(8), .DEPTH(6)) dut6 (.clk(clk), .rst(rst), .fifo_bus(b6.slave));

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 11) & 8'hFF);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b32.i_wreq = 1'b0; b32.i_rreq = 1'b0; b32.i_clr_err = 1'b0; b32.wdata = 8'h00;
        b6.i_wreq  = 1'b0; b6.i_rreq  = 1'b0; b6.i_clr_err  = 1'b0; b6.wdata  = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        b32.i_wreq = 1'b1; b32.i_rreq = 1'b1; b6.i_wreq = 1'b1; b6.i_rreq = 1'b1;
        step();
        rst = 1'b0;
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (b32.fifo_count !== 6'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", b32.fifo_count); end
        n_chk++; if (b32.fifo_isempty !== 1'b1) begin n_fail++; $display("FAIL rst_isempty: got %b want 1", b32.fifo_isempty); end
        n_chk++; if (b32.fifo_isfull !== 1'b0) begin n_fail++; $display("FAIL rst_isfull: got %b want 0", b32.fifo_isfull); end
        n_chk++; if (b32.fifo_almost_empty !== 1'b1) begin n_fail++; $display("FAIL rst_aempty: got %b want 1", b32.fifo_almost_empty); end
        n_chk++; if (b32.fifo_almost_full !== 1'b0) begin n_fail++; $display("FAIL rst_afull: got %b want 0", b32.fifo_almost_full); end
        n_chk++; if (b32.o_wready !== 1'b1) begin n_fail++; $display("FAIL rst_wready: got %b want 1", b32.o_wready); end
        n_chk++; if (b32.o_rready !== 1'b0) begin n_fail++; $display("FAIL rst_rready: got %b want 0", b32.o_rready); end
        n_chk++; if (b32.o_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", b32.o_rvalid); end
        n_chk++; if (b32.rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h want 00", b32.rdata); end
        n_chk++; if (b32.o_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", b32.o_overflow); end
        n_chk++; if (b32.o_underflow !== 1'b0) begin n_fail++; $display("FAIL rst_udf: got %b want 0", b32.o_underflow); end
        n_chk++; if (b6.fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count6: got %0d want 0", b6.fifo_count); end
    endtask

`ifndef CSV_SFIFO_FWFT_EN
    task automatic test_alternate();
        for (int i = 0; i < 10; i++) begin
            b32.wdata = pat(i); b32.i_wreq = 1'b1;
            step();
            b32.i_wreq = 1'b0; b32.i_rreq = 1'b1;
            step();
            b32.i_rreq = 1'b0;
            n_chk++; if (b32.rdata !== pat(i)) begin n_fail++; $display("FAIL alt_rdata[%0d]: got %h want %h", i, b32.rdata, pat(i)); end
            n_chk++; if (b32.o_rvalid !== 1'b1) begin n_fail++; $display("FAIL alt_rvalid[%0d]: got %b want 1", i, b32.o_rvalid); end
        end
        step();
        n_chk++; if (b32.fifo_count !== 6'd0) begin n_fail++; $display("FAIL alt_count: got %0d want 0", b32.fifo_count); end
        n_chk++; if (b32.o_rvalid !== 1'b0) begin n_fail++; $display("FAIL alt_rvalid_drop: got %b want 0", b32.o_rvalid); end
        n_chk++; if (b32.rdata !== pat(9)) begin n_fail++; $display("FAIL alt_rdata_hold: got %h want %h", b32.rdata, pat(9)); end
        n_chk++; if ({b32.o_overflow, b32.o_underflow} !== 2'b00) begin n_fail++; $display("FAIL alt_err: got %b want 00", {b32.o_overflow, b32.o_underflow}); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 32; i++) begin
            b32.wdata = pat(100 + i); b32.i_wreq = 1'b1;
            step();
            n_chk++; if (b32.fifo_count !== 6'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, b32.fifo_count, i + 1); end
            n_chk++; if (b32.fifo_almost_full !== (i + 1 >= 28)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b want %b", i, b32.fifo_almost_full, (i + 1 >= 28)); end
        end
        n_chk++; if (b32.fifo_isfull !== 1'b1) begin n_fail++; $display("FAIL fill_isfull: got %b want 1", b32.fifo_isfull); end
        n_chk++; if (b32.o_wready !== 1'b0) begin n_fail++; $display("FAIL fill_wready: got %b want 0", b32.o_wready); end
        n_chk++; if (b32.o_overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_early: got %b want 0", b32.o_overflow); end
        b32.wdata = 8'hEE;
        step();
        b32.i_wreq = 1'b0;
        n_chk++; if (b32.o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", b32.o_overflow); end
        n_chk++; if (b32.fifo_count !== 6'd32) begin n_fail++; $display("FAIL ovf_count: got %0d want 32", b32.fifo_count); end
        for (int i = 0; i < 32; i++) begin
            b32.i_rreq = 1'b1;
            step();
            n_chk++; if (b32.rdata !== pat(100 + i)) begin n_fail++; $display("FAIL drain_rdata[%0d]: got %h want %h", i, b32.rdata, pat(100 + i)); end
            n_chk++; if (b32.fifo_almost_empty !== (31 - i <= 4)) begin n_fail++; $display("FAIL drain_aempty[%0d]: got %b want %b", i, b32.fifo_almost_empty, (31 - i <= 4)); end
        end
        n_chk++; if (b32.fifo_isempty !== 1'b1) begin n_fail++; $display("FAIL drain_isempty: got %b want 1", b32.fifo_isempty); end
        n_chk++; if (b32.o_underflow !== 1'b0) begin n_fail++; $display("FAIL drain_udf_early: got %b want 0", b32.o_underflow); end
        step();
        b32.i_rreq = 1'b0;
        n_chk++; if (b32.o_underflow !== 1'b1) begin n_fail++; $display("FAIL udf_set: got %b want 1", b32.o_underflow); end
        n_chk++; if (b32.o_rvalid !== 1'b0) begin n_fail++; $display("FAIL udf_rvalid: got %b want 0", b32.o_rvalid); end
        n_chk++; if (b32.rdata !== pat(131)) begin n_fail++; $display("FAIL udf_rdata_hold: got %h want %h", b32.rdata, pat(131)); end
        step();
        n_chk++; if ({b32.o_overflow, b32.o_underflow} !== 2'b11) begin n_fail++; $display("FAIL err_sticky: got %b want 11", {b32.o_overflow, b32.o_underflow}); end
        b32.i_clr_err = 1'b1;
        step();
        b32.i_clr_err = 1'b0;
        n_chk++; if ({b32.o_overflow, b32.o_underflow} !== 2'b00) begin n_fail++; $display("FAIL err_clear: got %b want 00", {b32.o_overflow, b32.o_underflow}); end
        // A new error on the clearing edge must win.
        b32.i_rreq = 1'b1; b32.i_clr_err = 1'b1;
        step();
        b32.i_rreq = 1'b0; b32.i_clr_err = 1'b0;
        n_chk++; if (b32.o_underflow !== 1'b1) begin n_fail++; $display("FAIL err_set_over_clr: got %b want 1", b32.o_underflow); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            b32.wdata = pat(40 + i); b32.i_wreq = 1'b1;
            step();
        end
        b32.wdata = pat(45); b32.i_rreq = 1'b1;
        step();
        b32.i_wreq = 1'b0; b32.i_rreq = 1'b0;
        n_chk++; if (b32.fifo_count !== 6'd5) begin n_fail++; $display("FAIL sim5_count: got %0d want 5", b32.fifo_count); end
        n_chk++; if (b32.rdata !== pat(40)) begin n_fail++; $display("FAIL sim5_rdata: got %h want %h", b32.rdata, pat(40)); end

        do_reset();
        b32.wdata = pat(50); b32.i_wreq = 1'b1; b32.i_rreq = 1'b1;
        step();
        b32.i_rreq = 1'b0;
        n_chk++; if (b32.fifo_count !== 6'd1) begin n_fail++; $display("FAIL sim_empty_count: got %0d want 1", b32.fifo_count); end
        n_chk++; if ({b32.o_overflow, b32.o_underflow} !== 2'b01) begin n_fail++; $display("FAIL sim_empty_err: got %b want 01", {b32.o_overflow, b32.o_underflow}); end
        n_chk++; if (b32.o_rvalid !== 1'b0) begin n_fail++; $display("FAIL sim_empty_rvalid: got %b want 0", b32.o_rvalid); end
        for (int i = 1; i < 32; i++) begin
            b32.wdata = pat(50 + i);
            step();
        end
        n_chk++; if (b32.fifo_isfull !== 1'b1) begin n_fail++; $display("FAIL sim_full_pre: got %b want 1", b32.fifo_isfull); end
        b32.wdata = 8'h77; b32.i_rreq = 1'b1;
        step();
        b32.i_wreq = 1'b0;
        n_chk++; if (b32.fifo_count !== 6'd31) begin n_fail++; $display("FAIL sim_full_count: got %0d want 31", b32.fifo_count); end
        n_chk++; if (b32.rdata !== pat(50)) begin n_fail++; $display("FAIL sim_full_rdata: got %h want %h", b32.rdata, pat(50)); end
        n_chk++; if (b32.o_overflow !== 1'b1) begin n_fail++; $display("FAIL sim_full_ovf: got %b want 1", b32.o_overflow); end
        for (int i = 1; i < 32; i++) begin
            step();
            n_chk++; if (b32.rdata !== pat(50 + i)) begin n_fail++; $display("FAIL sim_full_drain[%0d]: got %h want %h", i, b32.rdata, pat(50 + i)); end
        end
        b32.i_rreq = 1'b0;
        n_chk++; if (b32.fifo_count !== 6'd0) begin n_fail++; $display("FAIL sim_full_end: got %0d want 0", b32.fifo_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            b6.wdata = pat(200 + i); b6.i_wreq = 1'b1;
            step();
        end
        for (int i = 0; i < 21; i++) begin
            b6.wdata = pat(203 + i); b6.i_wreq = 1'b1; b6.i_rreq = 1'b1;
            step();
            n_chk++; if (b6.rdata !== pat(200 + i)) begin n_fail++; $display("FAIL wrap_rdata[%0d]: got %h want %h", i, b6.rdata, pat(200 + i)); end
            n_chk++; if (b6.fifo_count !== 3'd3) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d want 3", i, b6.fifo_count); end
        end
        b6.i_wreq = 1'b0;
        for (int i = 21; i < 24; i++) begin
            step();
            n_chk++; if (b6.rdata !== pat(200 + i)) begin n_fail++; $display("FAIL wrap_tail[%0d]: got %h want %h", i, b6.rdata, pat(200 + i)); end
        end
        b6.i_rreq = 1'b0;
        n_chk++; if (b6.fifo_isempty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b want 1", b6.fifo_isempty); end
        n_chk++; if (dut6.wr_ptr !== 3'd0) begin n_fail++; $display("FAIL wrap_wr_ptr: got %0d want 0", dut6.wr_ptr); end
        n_chk++; if (dut6.rd_ptr !== 3'd0) begin n_fail++; $display("FAIL wrap_rd_ptr: got %0d want 0", dut6.rd_ptr); end
        n_chk++; if ({b6.o_overflow, b6.o_underflow} !== 2'b00) begin n_fail++; $display("FAIL wrap_err: got %b want 00", {b6.o_overflow, b6.o_underflow}); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            b32.wdata = pat(300 + i); b32.i_wreq = 1'b1;
            step();
        end
        b32.i_wreq = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b32.i_rreq = 1'b1;
            step();
        end
        n_chk++; if (b32.rdata !== pat(308)) begin n_fail++; $display("FAIL mid_pre_rdata: got %h want %h", b32.rdata, pat(308)); end
        n_chk++; if (b32.fifo_count !== 6'd1) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 1", b32.fifo_count); end
        do_reset();
        n_chk++; if (b32.fifo_count !== 6'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", b32.fifo_count); end
        n_chk++; if ({b32.fifo_isempty, b32.fifo_almost_empty, b32.o_wready} !== 3'b111) begin n_fail++; $display("FAIL mid_flags_hi: got %b want 111", {b32.fifo_isempty, b32.fifo_almost_empty, b32.o_wready}); end
        n_chk++; if ({b32.fifo_isfull, b32.fifo_almost_full, b32.o_rready, b32.o_rvalid} !== 4'b0000) begin n_fail++; $display("FAIL mid_flags_lo: got %b want 0000", {b32.fifo_isfull, b32.fifo_almost_full, b32.o_rready, b32.o_rvalid}); end
        n_chk++; if (b32.rdata !== 8'h00) begin n_fail++; $display("FAIL mid_rdata: got %h want 00", b32.rdata); end
        n_chk++; if ({b32.o_overflow, b32.o_underflow} !== 2'b00) begin n_fail++; $display("FAIL mid_err: got %b want 00", {b32.o_overflow, b32.o_underflow}); end
    endtask
`else
    task automatic test_fwft();
        do_reset();
        b32.wdata = 8'hAA; b32.i_wreq = 1'b1;
        step();
        b32.wdata = 8'hBB;
        n_chk++; if (b32.o_rvalid !== 1'b0) begin n_fail++; $display("FAIL fwft_rvalid_n: got %b want 0", b32.o_rvalid); end
        n_chk++; if (b32.fifo_count !== 6'd1) begin n_fail++; $display("FAIL fwft_count_n: got %0d want 1", b32.fifo_count); end
        step();
        b32.i_wreq = 1'b0;
        n_chk++; if (b32.o_rvalid !== 1'b1) begin n_fail++; $display("FAIL fwft_rvalid_n1: got %b want 1", b32.o_rvalid); end
        n_chk++; if (b32.rdata !== 8'hAA) begin n_fail++; $display("FAIL fwft_rdata_n1: got %h want aa", b32.rdata); end
        n_chk++; if (b32.fifo_count !== 6'd2) begin n_fail++; $display("FAIL fwft_count_n1: got %0d want 2", b32.fifo_count); end
        step();
        b32.i_rreq = 1'b1;
        step();
        n_chk++; if ({b32.o_rvalid, b32.rdata} !== {1'b1, 8'hBB}) begin n_fail++; $display("FAIL fwft_refill: got %b/%h want 1/bb", b32.o_rvalid, b32.rdata); end
        step();
        b32.i_rreq = 1'b0;
        n_chk++; if ({b32.o_rvalid, b32.fifo_count} !== {1'b0, 6'd0}) begin n_fail++; $display("FAIL fwft_empty: got %b/%0d want 0/0", b32.o_rvalid, b32.fifo_count); end
        n_chk++; if (b32.o_underflow !== 1'b0) begin n_fail++; $display("FAIL fwft_udf: got %b want 0", b32.o_underflow); end
    endtask
`endif

    initial begin
        idle();
        test_reset();
`ifndef CSV_SFIFO_FWFT_EN
        test_alternate();
        test_fill_drain();
        test_simultaneous();
        test_wrap();
        test_mid_reset();
`else
        test_fwft();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
